// File: rtl/flash_burst_seq.sv
// rtl/flash_burst_seq.sv - splits host read/program/erase commands into single-byte flash_ctrl transactions
module flash_burst_seq #(
  parameter int MAX_LEN = 256,
  parameter int GAP_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [23:0] i_cmd_addr,
  input  logic [8:0]  i_cmd_len,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [7:0]  i_wr_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_rd_req,
  output logic        o_pp_req,
  output logic        o_se_req,
  output logic [23:0] o_rd_addr,
  output logic [23:0] o_wr_addr,
  output logic [23:0] o_se_addr,
  output logic [7:0]  o_data_into_flash,
  input  logic        i_flash_ack,
  input  logic [7:0]  i_rdata
);

  localparam int              GW        = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [9:0]      MAX_LEN_W = 10'(MAX_LEN);
  localparam logic [1:0]      OP_RD     = 2'd0;
  localparam logic [1:0]      OP_PP     = 2'd1;
  localparam logic [1:0]      OP_SE     = 2'd2;
  localparam logic [1:0]      OP_BAD    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [23:0]   r_addr;
  logic [8:0]    r_rem;
  logic          r_err;
  logic [GW-1:0] r_gap_cnt;
  logic          r_rd_req;
  logic          r_pp_req;
  logic          r_se_req;
  logic          r_rd_valid;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_wr_byte;

  logic          w_cmd_bad;
  logic          w_rd_ok;
  logic          w_ack;
  logic          w_last;
  logic          w_pop;
  logic          w_accept;
  logic [1:0]    w_op;

  // A zero or oversized length only matters for commands that move data.
  assign w_cmd_bad = (i_cmd_op == OP_BAD) ||
                     ((i_cmd_op != OP_SE) &&
                      ((i_cmd_len == 9'd0) || ({1'b0, i_cmd_len} > MAX_LEN_W)));
  // The one-entry read buffer is free now, or is being emptied this cycle.
  assign w_rd_ok   = !r_rd_valid || i_rd_ready;
  assign w_pop     = r_rd_valid && i_rd_ready;
  assign w_ack     = (r_state == S_ISSUE) && i_flash_ack;
  assign w_last    = (r_op == OP_SE) || (r_rem == 9'd1);
  assign w_accept  = (r_state == S_IDLE) && i_cmd_valid;
  // In IDLE the op is being latched this edge, so the request type follows the input.
  assign w_op      = (r_state == S_IDLE) ? i_cmd_op : r_op;

  // Next-state selection; a read blocked by a still-pending byte parks in GAP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (w_cmd_bad)               w_next = S_DONE;
          else if (i_cmd_op == OP_PP)  w_next = S_FETCH;
          else if (i_cmd_op == OP_RD && !w_rd_ok) w_next = S_GAP;
          else                         w_next = S_ISSUE;
        end
      end
      S_FETCH: begin
        if (i_wr_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_flash_ack) w_next = w_last ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if ((r_gap_cnt == GAP_LAST) && ((r_op != OP_RD) || w_rd_ok))
          w_next = (r_op == OP_PP) ? S_FETCH : S_ISSUE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and the registered request lines, which are high exactly while in ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_rd_req <= 1'b0;
      r_pp_req <= 1'b0;
      r_se_req <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rd_req <= (w_next == S_ISSUE) && (w_op == OP_RD);
      r_pp_req <= (w_next == S_ISSUE) && (w_op == OP_PP);
      r_se_req <= (w_next == S_ISSUE) && (w_op == OP_SE);
    end
  end

  // Command context: latched on accept, address and remaining count stepped per acknowledged byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op      <= 2'd0;
      r_addr    <= 24'd0;
      r_rem     <= 9'd0;
      r_err     <= 1'b0;
      r_wr_byte <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_addr <= i_cmd_addr;
        r_rem  <= i_cmd_len;
        r_err  <= w_cmd_bad;
      end else if (w_ack) begin
        r_addr <= r_addr + 24'd1;
        r_rem  <= r_rem - 9'd1;
      end
      if ((r_state == S_FETCH) && i_wr_valid) r_wr_byte <= i_wr_data;
    end
  end

  // One-entry read buffer toward the host; loading and popping never coincide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'd0;
    end else if (w_ack && (r_op == OP_RD)) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= i_rdata;
    end else if (w_pop) begin
      r_rd_valid <= 1'b0;
    end
  end

  // Inter-transaction gap counter; a GAP entered from IDLE only waits for the read buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gap_cnt <= '0;
    end else if ((w_next == S_GAP) && (r_state != S_GAP)) begin
      r_gap_cnt <= (r_state == S_IDLE) ? GAP_LAST : '0;
    end else if ((r_state == S_GAP) && (r_gap_cnt != GAP_LAST)) begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  assign o_cmd_ready       = (r_state == S_IDLE)  && !i_reset;
  assign o_busy            = (r_state != S_IDLE)  && !i_reset;
  assign o_wr_ready        = (r_state == S_FETCH) && !i_reset;
  assign o_done            = (r_state == S_DONE)  && !i_reset;
  assign o_err             = o_done && r_err;
  assign o_rd_valid        = r_rd_valid;
  assign o_rd_data         = r_rd_data;
  assign o_rd_req          = r_rd_req;
  assign o_pp_req          = r_pp_req;
  assign o_se_req          = r_se_req;
  assign o_rd_addr         = r_addr;
  assign o_wr_addr         = r_addr;
  assign o_se_addr         = r_addr;
  assign o_data_into_flash = r_wr_byte;

endmodule
